// File: rtl/serial_bcd_to_excess3_pkg.sv
// Shared constants for the serial BCD <-> Excess-3 encoder/converter pair.
// Both the encoder RTL and the testbenches import this package.
package serial_bcd_to_excess3_pkg;

  localparam logic [2:0] ST_B0   = 3'd0;
  localparam logic [2:0] ST_B1C0 = 3'd1;
  localparam logic [2:0] ST_B1C1 = 3'd2;
  localparam logic [2:0] ST_B2C0 = 3'd3;
  localparam logic [2:0] ST_B2C1 = 3'd4;
  localparam logic [2:0] ST_B3C0 = 3'd5;
  localparam logic [2:0] ST_B3C1 = 3'd6;

  localparam logic [3:0] ADDEND  = 4'b0011;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    B0   = ST_B0,
    B1C0 = ST_B1C0,
    B1C1 = ST_B1C1,
    B2C0 = ST_B2C0,
    B2C1 = ST_B2C1,
    B3C0 = ST_B3C0,
    B3C1 = ST_B3C1
  } state_t;

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/serial_bcd_to_excess3_if.sv
// Serial data/flag bundle between a bit source (master) and the encoder (slave).
interface serial_bcd_to_excess3_if #(parameter int CNT_W = 8);

  logic             X;
  logic             En;
  logic             Z;
  logic             DigitDone;
  logic             Err;
  logic [CNT_W-1:0] ErrCnt;

  modport master (output X, En, input Z, DigitDone, Err, ErrCnt);
  modport slave  (input X, En, output Z, DigitDone, Err, ErrCnt);

endinterface

// File: rtl/serial_bcd_to_excess3_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Inc,
  output logic [W-1:0] Q
);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Q <= '0;
    end else if (Inc && (Q != '1)) begin
      Q <= Q + W'(1);
    end
  end

endmodule

// File: rtl/serial_bcd_to_excess3.sv
// Serial BCD to Excess-3 encoder: LSB-first bit-serial add of 0011 with a
// Mealy output, plus detection and saturating count of non-BCD digits.
module serial_bcd_to_excess3
  import serial_bcd_to_excess3_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                    Clk,
  input  logic                    Rst,
  serial_bcd_to_excess3_if.slave  bus
);

  state_t state;
  state_t stateNext;
  logic   hi;
  logic   hiNext;
  logic   zBit;
  logic   digitDone;
  logic   err;
  logic   errGated;
  logic   carryOut;
  logic   addBit;
  logic   carryIn;
  logic [1:0] bitIdx;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= B0;
      hi    <= 1'b0;
    end else begin
      state <= stateNext;
      hi    <= hiNext;
    end
  end

  // Each state encodes (bit index, incoming carry); one full-adder step per bit.
  always_comb begin
    stateNext = state;
    hiNext    = hi;
    zBit      = 1'b0;
    digitDone = 1'b0;
    err       = 1'b0;
    bitIdx    = 2'd0;
    carryIn   = 1'b0;
    case (state)
      B0:      begin bitIdx = 2'd0; carryIn = 1'b0; end
      B1C0:    begin bitIdx = 2'd1; carryIn = 1'b0; end
      B1C1:    begin bitIdx = 2'd1; carryIn = 1'b1; end
      B2C0:    begin bitIdx = 2'd2; carryIn = 1'b0; end
      B2C1:    begin bitIdx = 2'd2; carryIn = 1'b1; end
      B3C0:    begin bitIdx = 2'd3; carryIn = 1'b0; end
      B3C1:    begin bitIdx = 2'd3; carryIn = 1'b1; end
      default: begin bitIdx = 2'd0; carryIn = 1'b0; end
    endcase
    addBit   = ADDEND[bitIdx];
    carryOut = (bus.X & addBit) | (bus.X & carryIn) | (addBit & carryIn);
    if (bus.En) begin
      zBit = bus.X ^ addBit ^ carryIn;
      case (bitIdx)
        2'd0: stateNext = carryOut ? B1C1 : B1C0;
        2'd1: stateNext = carryOut ? B2C1 : B2C0;
        2'd2: stateNext = carryOut ? B3C1 : B3C0;
        default: stateNext = B0;
      endcase
      if ((bitIdx == 2'd1 || bitIdx == 2'd2) && bus.X) begin
        hiNext = 1'b1;
      end
      if (bitIdx == 2'd3) begin
        hiNext    = 1'b0;
        digitDone = 1'b1;
        err       = bus.X & hi;
      end
    end
  end

  // Outputs are combinational, so reset must mask them explicitly.
  assign errGated      = err & Rst;
  assign bus.Z         = zBit & Rst;
  assign bus.DigitDone = digitDone & Rst;
  assign bus.Err       = errGated;

  sat_counter #(.W(CNT_W)) errCounter (
    .Clk (Clk),
    .Rst (Rst),
    .Inc (errGated),
    .Q   (bus.ErrCnt)
  );

endmodule

// File: tb/tb_serial_bcd_to_excess3.sv
// Directed bench for serial_bcd_to_excess3: one task per scenario, inputs
// driven just after the rising edge and outputs sampled on the falling edge.
module tb_serial_bcd_to_excess3;
  import serial_bcd_to_excess3_pkg::*;

  logic Clk;
  logic Rst;
  int   errors;
  int   checks;

  serial_bcd_to_excess3_if #(.CNT_W(8)) bus1 ();
  serial_bcd_to_excess3_if #(.CNT_W(2)) bus2 ();

  serial_bcd_to_excess3 #(.CNT_W(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus1.slave)
  );

  serial_bcd_to_excess3 #(.CNT_W(2)) dutSat (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus2.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic drive1(input logic x, input logic en,
                        output logic z, output logic dd, output logic er);
    bus1.X  = x;
    bus1.En = en;
    @(negedge Clk);
    z  = bus1.Z;
    dd = bus1.DigitDone;
    er = bus1.Err;
    @(posedge Clk);
    #1;
  endtask

  task automatic send1(input logic [3:0] d, output logic [3:0] zf,
                       output logic [3:0] ddf, output logic [3:0] erf);
    for (int i = 0; i < 4; i++) begin
      drive1(d[i], 1'b1, zf[i], ddf[i], erf[i]);
    end
    bus1.En = 1'b0;
  endtask

  task automatic send2(input logic [3:0] d, output logic [3:0] erf);
    for (int i = 0; i < 4; i++) begin
      bus2.X  = d[i];
      bus2.En = 1'b1;
      @(negedge Clk);
      erf[i] = bus2.Err;
      @(posedge Clk);
      #1;
    end
    bus2.En = 1'b0;
  endtask

  task automatic test_reset();
    logic z, dd, er;
    Rst = 1'b0;
    bus1.X = 1'b0; bus1.En = 1'b1;
    bus2.X = 1'b0; bus2.En = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if (bus1.Z !== 1'b0 || bus1.DigitDone !== 1'b0 || bus1.Err !== 1'b0 || bus1.ErrCnt !== 8'd0) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc%0d: Z=%b DD=%b Err=%b Cnt=%0d, want all 0", i, bus1.Z, bus1.DigitDone, bus1.Err, bus1.ErrCnt);
      end
    end
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive1(1'b1, 1'b0, z, dd, er);
      checks++;
      if (z !== 1'b0 || dd !== 1'b0 || er !== 1'b0 || bus1.ErrCnt !== 8'd0 || bus2.ErrCnt !== 2'd0) begin
        errors++;
        $display("[TB] FAIL reset_idle cyc%0d: Z=%b DD=%b Err=%b Cnt=%0d Cnt2=%0d, want all 0", i, z, dd, er, bus1.ErrCnt, bus2.ErrCnt);
      end
    end
  endtask

  task automatic test_valid_digits();
    logic [3:0] expVal [10] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    logic [3:0] zf, ddf, erf;
    for (int d = 0; d < 10; d++) begin
      send1(4'(d), zf, ddf, erf);
      checks++;
      if (zf !== expVal[d] || ddf !== 4'b1000 || erf !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL valid_digit %0d: Z=%b DD=%b Err=%b, want Z=%b DD=1000 Err=0000", d, zf, ddf, erf, expVal[d]);
      end
    end
  endtask

  task automatic test_invalid_digits();
    logic [3:0] digits [4] = '{4'b1010, 4'b1100, 4'b1111, 4'b1000};
    logic [3:0] expZ   [4] = '{4'b1101, 4'b1111, 4'b0010, 4'b1011};
    logic [7:0] expCnt [4] = '{8'd1, 8'd2, 8'd3, 8'd3};
    logic [3:0] zf, ddf, erf, expErr;
    for (int k = 0; k < 4; k++) begin
      send1(digits[k], zf, ddf, erf);
      expErr = digit_invalid(digits[k]) ? 4'b1000 : 4'b0000;
      checks++;
      if (zf !== expZ[k] || erf !== expErr || bus1.ErrCnt !== expCnt[k]) begin
        errors++;
        $display("[TB] FAIL invalid_digit %b: Z=%b Err=%b Cnt=%0d, want Z=%b Err=%b Cnt=%0d", digits[k], zf, erf, bus1.ErrCnt, expZ[k], expErr, expCnt[k]);
      end
    end
  endtask

  task automatic test_en_gaps();
    logic [3:0] d = 4'b0111;
    logic [3:0] zf, ddf;
    logic z, dd, er;
    logic idleBad;
    idleBad = 1'b0;
    zf = '0; ddf = '0;
    for (int i = 0; i < 4; i++) begin
      drive1(d[i], 1'b1, zf[i], ddf[i], er);
      if (i == 0 || i == 2) begin
        for (int g = 0; g < 2; g++) begin
          drive1(1'b1, 1'b0, z, dd, er);
          if (z !== 1'b0 || dd !== 1'b0 || er !== 1'b0) idleBad = 1'b1;
        end
      end
    end
    bus1.En = 1'b0;
    checks++;
    if (zf !== 4'b1010 || ddf !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL en_gap_frame: Z=%b DD=%b, want Z=1010 DD=1000", zf, ddf);
    end
    checks++;
    if (idleBad !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_gap_idle: idle outputs nonzero=%b, want 0", idleBad);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] zf, ddf, erf;
    logic z, dd, er;
    drive1(1'b1, 1'b1, z, dd, er);
    drive1(1'b1, 1'b1, z, dd, er);
    bus1.X  = 1'b0;
    bus1.En = 1'b1;
    Rst = 1'b0;
    #1;
    checks++;
    if (bus1.Z !== 1'b0 || bus1.DigitDone !== 1'b0 || bus1.ErrCnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_pulse: Z=%b DD=%b Cnt=%0d, want 0 0 0", bus1.Z, bus1.DigitDone, bus1.ErrCnt);
    end
    #1;
    Rst = 1'b1;
    send1(4'b0100, zf, ddf, erf);
    checks++;
    if (zf !== 4'b0111 || ddf !== 4'b1000 || erf !== 4'b0000 || bus1.ErrCnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_frame: Z=%b DD=%b Err=%b Cnt=%0d, want Z=0111 DD=1000 Err=0000 Cnt=0", zf, ddf, erf, bus1.ErrCnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d, zf, ddf, erf, recovered;
    for (int n = 0; n < 10000; n++) begin
      d = 4'($urandom_range(0, 9));
      send1(d, zf, ddf, erf);
      recovered = zf - 4'd3;
      checks++;
      if (recovered !== d || ddf !== 4'b1000 || erf !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL loopback frame %0d: recovered=%0d DD=%b Err=%b, want %0d DD=1000 Err=0000", n, recovered, ddf, erf, d);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] expCnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [3:0] erf;
    for (int k = 0; k < 5; k++) begin
      send2(4'b1111, erf);
      checks++;
      if (bus2.ErrCnt !== expCnt[k] || erf !== 4'b1000) begin
        errors++;
        $display("[TB] FAIL saturation step %0d: Cnt=%0d Err=%b, want Cnt=%0d Err=1000", k, bus2.ErrCnt, erf, expCnt[k]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_valid_digits();
    test_invalid_digits();
    test_en_gaps();
    test_reset_mid_frame();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
